// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and defaults for the memory access controller
// Contents: state enum, requester owner encoding, default address width.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACCESS,
    CAPTURE,
    DONE,
    ERROR
  } mac_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/strobe bundle between control unit, controller and MAR/MDR/memory
// Signals: fetch_req/fetch_addr, data_req/data_we/data_addr, mem_ready (into the controller);
//          MAR_load/MAR_addr, mem_rd/mem_wr, MDR_load_mem/MDR_bus_out_en, done_fetch/done_data, err (out).
// Modports: slave = the controller, master = the requesters/memory side.
interface mem_access_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic              mem_ready;
  logic              MAR_load;
  logic [ADDR_W-1:0] MAR_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic              MDR_load_mem;
  logic              MDR_bus_out_en;
  logic              done_fetch;
  logic              done_data;
  logic              err;

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, mem_ready,
    output MAR_load, MAR_addr, mem_rd, mem_wr, MDR_load_mem, MDR_bus_out_en,
           done_fetch, done_data, err
  );

  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, mem_ready,
    input  MAR_load, MAR_addr, mem_rd, mem_wr, MDR_load_mem, MDR_bus_out_en,
           done_fetch, done_data, err
  );
endinterface

// File: rtl/mac_wait_timer.sv
// rtl/mac_wait_timer.sv - ACCESS-phase wait counter with minimum-wait and timeout flags
// Ports: clk_i, rst_ni (async active-low), clear_i (load 0), count_i (advance),
//        min_reached_o (count >= WAIT_CYCLES), timeout_o (count == TIMEOUT-1).
module mac_wait_timer #(
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic min_reached_o,
  output logic timeout_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT so the counter can never wrap back below the thresholds.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (WAIT_CYCLES == 0) begin : g_no_wait
      assign min_reached_o = 1'b1;
    end else begin : g_wait
      assign min_reached_o = (cnt_q >= CW'(WAIT_CYCLES));
    end
  endgenerate

  assign timeout_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - fetch/data arbiter and MAR/MDR transaction sequencer
// Ports: MAC_clock, MAC_reset (async active-low), bus (slave modport of mem_access_ctrl_if).
// All bus outputs come from registers loaded with the decode of the next state.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT     = 15,
  parameter int STARVE_MAX  = 2
) (
  input  logic               MAC_clock,
  input  logic               MAC_reset,
  mem_access_ctrl_if.slave   bus
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  mac_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic              mar_load_q, mar_load_d;
  logic [ADDR_W-1:0] mar_addr_q, mar_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mdr_load_q, mdr_load_d;
  logic              bus_en_q, bus_en_d;
  logic              done_fetch_q, done_fetch_d;
  logic              done_data_q, done_data_d;
  logic              err_q, err_d;

  logic              min_reached;
  logic              timed_out;

  mac_wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) u_wait_timer (
    .clk_i         (MAC_clock),
    .rst_ni        (MAC_reset),
    .clear_i       (state_q == ADDR),
    .count_i       (state_q == ACCESS),
    .min_reached_o (min_reached),
    .timeout_o     (timed_out)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    starve_d = starve_q;

    case (state_q)
      IDLE: begin
        if (bus.data_req && !(bus.fetch_req && (starve_q == SW'(STARVE_MAX)))) begin
          owner_d = OWN_DATA;
          we_d    = bus.data_we;
          addr_d  = bus.data_addr;
          state_d = ADDR;
          // Reaching here with fetch pending implies starve_q < STARVE_MAX,
          // so the increment saturates naturally.
          if (bus.fetch_req) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (bus.fetch_req) begin
          owner_d  = OWN_FETCH;
          we_d     = 1'b0;
          addr_d   = bus.fetch_addr;
          starve_d = '0;
          state_d  = ADDR;
        end
      end
      ADDR:    state_d = ACCESS;
      ACCESS: begin
        if (min_reached && bus.mem_ready) begin
          state_d = we_q ? DONE : CAPTURE;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobes line up with the state.
  always_comb begin
    mar_load_d   = (state_d == ADDR);
    mar_addr_d   = (state_d == ADDR) ? addr_d : mar_addr_q;
    mem_rd_d     = (state_d == ACCESS) && !we_d;
    mem_wr_d     = (state_d == ACCESS) && we_d;
    mdr_load_d   = (state_d == CAPTURE);
    bus_en_d     = (state_d == DONE) && !we_d;
    done_fetch_d = (state_d == DONE) && (owner_d == OWN_FETCH);
    done_data_d  = (state_d == DONE) && (owner_d == OWN_DATA);
    err_d        = (state_d == ERROR);
  end

  always_ff @(posedge MAC_clock or negedge MAC_reset) begin
    if (!MAC_reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_FETCH;
      we_q         <= 1'b0;
      addr_q       <= '0;
      starve_q     <= '0;
      mar_load_q   <= 1'b0;
      mar_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mdr_load_q   <= 1'b0;
      bus_en_q     <= 1'b0;
      done_fetch_q <= 1'b0;
      done_data_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      starve_q     <= starve_d;
      mar_load_q   <= mar_load_d;
      mar_addr_q   <= mar_addr_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mdr_load_q   <= mdr_load_d;
      bus_en_q     <= bus_en_d;
      done_fetch_q <= done_fetch_d;
      done_data_q  <= done_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.MAR_load       = mar_load_q;
  assign bus.MAR_addr       = mar_addr_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_wr         = mem_wr_q;
  assign bus.MDR_load_mem   = mdr_load_q;
  assign bus.MDR_bus_out_en = bus_en_q;
  assign bus.done_fetch     = done_fetch_q;
  assign bus.done_data      = done_data_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
// Output vector bits: {MAR_load, mem_rd, mem_wr, MDR_load_mem, MDR_bus_out_en, done_fetch, done_data, err}
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_grant [6] = '{1, 1, 0, 1, 1, 0};
  int   grants [6];

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(16)) if_a ();
  mem_access_ctrl_if #(.ADDR_W(16)) if_b ();

  mem_access_ctrl #(.ADDR_W(16), .WAIT_CYCLES(1), .TIMEOUT(15), .STARVE_MAX(2)) dut_a (
    .MAC_clock (clk),
    .MAC_reset (rst_n),
    .bus       (if_a.slave)
  );

  mem_access_ctrl #(.ADDR_W(16), .WAIT_CYCLES(3), .TIMEOUT(15), .STARVE_MAX(2)) dut_b (
    .MAC_clock (clk),
    .MAC_reset (rst_n),
    .bus       (if_b.slave)
  );

  function automatic logic [7:0] vec_a();
    return {if_a.MAR_load, if_a.mem_rd, if_a.mem_wr, if_a.MDR_load_mem,
            if_a.MDR_bus_out_en, if_a.done_fetch, if_a.done_data, if_a.err};
  endfunction

  function automatic logic [7:0] vec_b();
    return {if_b.MAR_load, if_b.mem_rd, if_b.mem_wr, if_b.MDR_load_mem,
            if_b.MDR_bus_out_en, if_b.done_fetch, if_b.done_data, if_b.err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input bit use_b, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, {24'd0, (use_b ? vec_b() : vec_a())}, {24'd0, exp});
  endtask

  task automatic fetch_read_a(input string tag, input logic [15:0] addr);
    if_a.mem_ready  = 1'b1;
    if_a.fetch_addr = addr;
    if_a.fetch_req  = 1'b1;
    step({tag, " c1"}, 1'b0, 8'h80);
    chk({tag, " mar"}, {16'd0, if_a.MAR_addr}, {16'd0, addr});
    if_a.fetch_req = 1'b0;
    step({tag, " c2"}, 1'b0, 8'h40);
    step({tag, " c3"}, 1'b0, 8'h40);
    step({tag, " c4"}, 1'b0, 8'h10);
    step({tag, " c5"}, 1'b0, 8'h0C);
    step({tag, " c6"}, 1'b0, 8'h00);
    chk({tag, " mar hold"}, {16'd0, if_a.MAR_addr}, {16'd0, addr});
  endtask

  initial begin
    int got;
    logic done_seen;

    if_a.fetch_req = 0; if_a.fetch_addr = '0; if_a.data_req = 0;
    if_a.data_we = 0; if_a.data_addr = '0; if_a.mem_ready = 0;
    if_b.fetch_req = 0; if_b.fetch_addr = '0; if_b.data_req = 0;
    if_b.data_we = 0; if_b.data_addr = '0; if_b.mem_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset outs a", {24'd0, vec_a()}, 32'd0);
    chk("reset mar a", {16'd0, if_a.MAR_addr}, 32'd0);
    chk("reset outs b", {24'd0, vec_b()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch read, WAIT_CYCLES = 1
    fetch_read_a("fetch", 16'h0040);

    // Data store, ready on third ACCESS cycle
    if_a.mem_ready = 1'b0;
    if_a.data_addr = 16'h1234;
    if_a.data_we   = 1'b1;
    if_a.data_req  = 1'b1;
    step("store c1", 1'b0, 8'h80);
    chk("store mar", {16'd0, if_a.MAR_addr}, 32'h1234);
    if_a.data_req = 1'b0;
    step("store c2", 1'b0, 8'h20);
    step("store c3", 1'b0, 8'h20);
    step("store c4", 1'b0, 8'h20);
    if_a.mem_ready = 1'b1;
    step("store c5", 1'b0, 8'h02);
    step("store c6", 1'b0, 8'h00);

    // Contention with anti-starvation
    if_a.data_we    = 1'b0;
    if_a.data_addr  = 16'h2000;
    if_a.fetch_addr = 16'h0100;
    if_a.fetch_req  = 1'b1;
    if_a.data_req   = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      @(negedge clk);
      if (if_a.done_data) begin
        grants[got] = 1; got++;
      end else if (if_a.done_fetch) begin
        grants[got] = 0; got++;
      end
    end
    if_a.fetch_req = 1'b0;
    if_a.data_req  = 1'b0;
    chk("grant count", got, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("grant %0d", i), grants[i], exp_grant[i]);
    end
    step("contention idle", 1'b0, 8'h00);

    // Timeout
    if_a.mem_ready  = 1'b0;
    if_a.fetch_addr = 16'h0300;
    if_a.fetch_req  = 1'b1;
    step("tmo c1", 1'b0, 8'h80);
    if_a.fetch_req = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      step($sformatf("tmo c%0d", i), 1'b0, 8'h40);
    end
    step("tmo err", 1'b0, 8'h01);
    step("tmo idle", 1'b0, 8'h00);
    fetch_read_a("after tmo", 16'h0041);

    // Asynchronous reset during ACCESS
    if_a.mem_ready  = 1'b0;
    if_a.fetch_addr = 16'h0500;
    if_a.fetch_req  = 1'b1;
    step("rst c1", 1'b0, 8'h80);
    if_a.fetch_req = 1'b0;
    step("rst c2", 1'b0, 8'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async outs", {24'd0, vec_a()}, 32'd0);
    chk("rst async mar", {16'd0, if_a.MAR_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      done_seen = done_seen | if_a.done_fetch | if_a.done_data | if_a.err;
    end
    chk("rst no done", {31'd0, done_seen}, 32'd0);
    fetch_read_a("after rst", 16'h0040);

    // Early ready ignored, WAIT_CYCLES = 3
    if_b.mem_ready  = 1'b1;
    if_b.fetch_addr = 16'h0080;
    if_b.fetch_req  = 1'b1;
    step("early c1", 1'b1, 8'h80);
    if_b.fetch_req = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      step($sformatf("early c%0d", i), 1'b1, 8'h40);
    end
    step("early c6", 1'b1, 8'h10);
    step("early c7", 1'b1, 8'h0C);
    step("early c8", 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
